// File: rtl/ex_muldiv_seq_pkg.sv
// Shared types for the EX-stage RV32M multiply/divide sequencer.
package cpu_types;

  localparam int MULDIV_ITERS = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } muldiv_state_e;

  // rs1 is interpreted as signed by these ops
  function automatic logic op_signed_a(input muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_signed_b(input muldiv_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/ex_muldiv_seq_iter_dp.sv
// Iterative datapath: one shift-add multiply or restoring-divide step per enable.
// hi holds the upper product / partial remainder, lo the multiplier / quotient.
module muldiv_iter_dp
  import cpu_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            en,
  input  logic            div_mode,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  output logic [XLEN-1:0] hi_step,
  output logic [XLEN-1:0] lo_step
);

  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] md;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // Step results are exported so the sequencer can capture the final value
  // on the same edge that performs the last iteration.
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, md} : '0);
    shifted = {hi, lo[XLEN-1]};
    diff    = shifted - {1'b0, md};
    hi_step = sum[XLEN:1];
    lo_step = {sum[0], lo[XLEN-1:1]};
    if (div_mode) begin
      if (diff[XLEN]) begin
        hi_step = shifted[XLEN-1:0];
        lo_step = {lo[XLEN-2:0], 1'b0};
      end else begin
        hi_step = diff[XLEN-1:0];
        lo_step = {lo[XLEN-2:0], 1'b1};
      end
    end
  end

  // Multiply is commutative, so a goes to lo and b to md for both modes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
      md <= '0;
    end else if (load) begin
      hi <= '0;
      lo <= a_in;
      md <= b_in;
    end else if (en) begin
      hi <= hi_step;
      lo <= lo_step;
    end
  end

endmodule

// File: rtl/ex_muldiv_seq.sv
// RV32M sequencer: FSM, iteration counter, sign fixup and pipeline stall; done_o 33 cycles
// after acceptance (1 for div-by-zero/overflow). MULDIV_FAST_MUL_EN selects a 1-cycle multiply.
module ex_muldiv_seq
  import cpu_types::*;
#(
  parameter int XLEN  = 32,
  parameter int ITERS = MULDIV_ITERS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int              CW      = $clog2(ITERS);
  localparam logic [CW-1:0]   LAST    = CW'(ITERS - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     state, state_nxt;
  logic [CW-1:0]     cnt;
  muldiv_op_e        op_q, op_in, fop;
  logic              neg_q, rneg_q, fneg, frneg;
  logic [XLEN-1:0]   result_q, res_nxt;
  logic              res_ld, accept, busy, step_en;
  logic              a_neg, b_neg, div_zero, div_ovf, fast_done;
  logic [XLEN-1:0]   mag_a, mag_b, hi_step, lo_step;
  logic [2*XLEN-1:0] full, prod;

  assign op_in    = muldiv_op_e'(funct3_i);
  assign accept   = start_i & ~kill_i & (state == ST_IDLE);
  assign busy     = (state == ST_MUL) | (state == ST_DIV);
  assign step_en  = busy & ~kill_i;

  assign a_neg    = op_signed_a(op_in) & op_a_i[XLEN-1];
  assign b_neg    = op_signed_b(op_in) & op_b_i[XLEN-1];
  assign mag_a    = a_neg ? -op_a_i : op_a_i;
  assign mag_b    = b_neg ? -op_b_i : op_b_i;
  assign div_zero = funct3_i[2] & (op_b_i == '0);
  assign div_ovf  = ((op_in == OP_DIV) | (op_in == OP_REM)) &
                    (op_a_i == MIN_NEG) & (op_b_i == '1);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
  assign fast_done = ~funct3_i[2];
`else
  assign fast_done = 1'b0;
`endif

  muldiv_iter_dp #(.XLEN(XLEN)) u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .en       (step_en),
    .div_mode (state == ST_DIV),
    .a_in     (mag_a),
    .b_in     (mag_b),
    .hi_step  (hi_step),
    .lo_step  (lo_step)
  );

  // In IDLE the result comes straight from the inputs (special cases or the
  // fast product); otherwise from the datapath's final step.
  always_comb begin
    fop   = op_q;
    fneg  = neg_q;
    frneg = rneg_q;
    full  = {hi_step, lo_step};
    if (state == ST_IDLE) begin
      fop   = op_in;
      fneg  = a_neg ^ b_neg;
      frneg = a_neg;
`ifdef MULDIV_FAST_MUL_EN
      full  = fast_prod;
`else
      full  = '0;
`endif
    end
    prod = fneg ? -full : full;
    case (fop)
      OP_MUL:                       res_nxt = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_nxt = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              res_nxt = fneg ? -full[XLEN-1:0] : full[XLEN-1:0];
      default:                      res_nxt = frneg ? -full[2*XLEN-1:XLEN] : full[2*XLEN-1:XLEN];
    endcase
    if (state == ST_IDLE) begin
      if (div_zero)     res_nxt = funct3_i[1] ? op_a_i : '1;
      else if (div_ovf) res_nxt = funct3_i[1] ? '0 : MIN_NEG;
    end
  end

  always_comb begin
    state_nxt = state;
    res_ld    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (div_zero | div_ovf | fast_done) begin
            state_nxt = ST_DONE;
            res_ld    = 1'b1;
          end else if (funct3_i[2]) begin
            state_nxt = ST_DIV;
          end else begin
            state_nxt = ST_MUL;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (kill_i) begin
          state_nxt = ST_IDLE;
        end else if (cnt == LAST) begin
          state_nxt = ST_DONE;
          res_ld    = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt    <= '0;
        op_q   <= op_in;
        neg_q  <= a_neg ^ b_neg;
        rneg_q <= a_neg;
      end else if (step_en) begin
        cnt <= cnt + 1'b1;
      end
      if (res_ld) result_q <= res_nxt;
    end
  end

  // Dropping stall in DONE lets the held instruction leave without restarting.
  assign stall_o  = start_i & ~kill_i & (state != ST_DONE);
  assign done_o   = (state == ST_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq against an arithmetic RV32M reference.
module tb_ex_muldiv_seq;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        stall, done;
  logic [31:0] result;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] last_exp = 32'd0;

  ex_muldiv_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .kill_i   (kill),
    .funct3_i (funct3),
    .op_a_i   (op_a),
    .op_b_i   (op_b),
    .stall_o  (stall),
    .done_o   (done),
    .result_o (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    int          ia, ib;
    bit          ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'd0, b});
    ia  = a;
    ib  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return ia % ib;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return MUL_LAT;
    if (b == 0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Start an op (entered at a negedge), hold start until done, scramble
  // inputs while busy, then check latency, result and stall behaviour.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit hold, input string tag);
    logic [31:0] exp_r;
    int          lat, cyc;
    bit          st_ok;
    exp_r  = ref_op(f, a, b);
    lat    = ref_lat(f, a, b);
    start  = 1'b1;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    #1;
    if (done) begin
      chk({tag, "_stall_in_prev_done"}, stall, 1'b0);
      @(negedge clk);
    end
    cyc   = 0;
    st_ok = 1'b1;
    while (!done && cyc < 100) begin
      if (!stall) st_ok = 1'b0;
      @(negedge clk);
      cyc++;
      if (!done) begin
        op_a   = $urandom;
        op_b   = $urandom;
        funct3 = 3'($urandom);
      end
    end
    chk({tag, "_latency"}, cyc, lat);
    chk({tag, "_result"}, result, exp_r);
    chk({tag, "_stall_busy"}, st_ok, 1'b1);
    chk({tag, "_stall_done"}, stall, 1'b0);
    last_exp = exp_r;
    if (!hold) start = 1'b0;
  endtask

  initial begin
    bit saw;
    #1;
    chk("reset_done", done, 1'b0);
    chk("reset_result", result, 32'd0);
    chk("reset_stall", stall, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, "mul_7_m3");
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu_ones");
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulh_ones");
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu_ones");
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, "rem_m7_2");
    do_op(3'd5, 32'd100, 32'd7, 0, "divu_100_7");
    do_op(3'd7, 32'd100, 32'd7, 0, "remu_100_7");
    do_op(3'd5, 32'd5, 32'd0, 0, "divu_by_zero");
    do_op(3'd6, 32'd5, 32'd0, 0, "rem_by_zero");
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
    do_op(3'd0, 32'd3, 32'd4, 0, "mul_3_4");

    // DIV killed at N+10; start relaunched at N+12
    @(negedge clk);
    start = 1'b1; kill = 1'b0; funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd7;
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) saw = 1'b1;
    end
    kill = 1'b1;
    #1;
    chk("kill_stall", stall, 1'b0);
    @(negedge clk);
    kill = 1'b0; start = 1'b0;
    #1;
    if (done) saw = 1'b1;
    chk("kill_no_done", saw, 1'b0);
    chk("kill_result_hold", result, last_exp);
    @(negedge clk);
    do_op(3'd5, 32'd1000, 32'd7, 0, "divu_after_kill");

    // kill in IDLE blocks acceptance
    @(negedge clk);
    start = 1'b1; kill = 1'b1; funct3 = 3'd4; op_a = 32'd9; op_b = 32'd0;
    #1;
    chk("kill_idle_stall", stall, 1'b0);
    saw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) saw = 1'b1;
    end
    chk("kill_idle_no_done", saw, 1'b0);
    start = 1'b0; kill = 1'b0;
    @(negedge clk);

    do_op(3'd0, 32'd11, 32'd13, 1, "b2b_first");
    do_op(3'd0, 32'hFFFF_FFFE, 32'd21, 0, "b2b_second");

    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom_range(0, 7)), pick(), pick(), bit'($urandom_range(0, 1)), "rand");
    end
    start = 1'b0;
    @(negedge clk);

    // reset in the middle of an op clears outputs at once
    do_op(3'd0, 32'd5, 32'd6, 0, "pre_reset_mul");
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_done", done, 1'b0);
    chk("midreset_result", result, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw = 1'b1;
    end
    chk("midreset_no_done", saw, 1'b0);
    do_op(3'd7, 32'd1234, 32'd10, 0, "post_reset_remu");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_seq.md
Name: ex_muldiv_seq

Overview:
- Multi-cycle RV32M sequencer beside the EX-stage ALU; handles MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Takes the already-forwarded operands and funct3 from the ID/EX instruction.
- Runs an iterative shift-add multiply or restoring divide.
- Holds the pipeline via a stall request until the result is ready; the result is muxed into the EX/MEM alu_out path on the done cycle.

Parameters:
- XLEN, 32, operand/result width.
- ITERS, 32, iterations per mul/div; must equal XLEN.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  ID/EX holds a valid M-extension op; held high while stalled.
- kill_i  in  1  synchronous abort; flush of the ID/EX slot.
- funct3_i  in  3  M-op select.
- op_a_i  in  XLEN  rs1 after forwarding.
- op_b_i  in  XLEN  rs2 after forwarding.
- stall_o  out  1  freeze PC, IF/ID and ID/EX; insert bubble into EX/MEM.
- done_o  out  1  result valid this cycle; the instruction advances.
- result_o  out  XLEN  M-op result.

Behaviour:
- Reset (async, rst_n low): state IDLE, counter 0, done_o 0, result_o 0, all internal registers 0.
- State machine:
  - IDLE: start_i & ~kill_i latches funct3 and operands.
    - Div/rem by zero, or signed overflow (-2^31 / -1) → DONE directly.
    - Other mul ops → MUL; other div/rem ops → DIV.
  - MUL / DIV: one iteration per cycle; counter 0..ITERS-1; on counter == ITERS-1 → DONE.
  - DONE: done_o = 1, result_o valid; unconditionally → IDLE next cycle.
- Latency: start first seen in IDLE at cycle N → done_o at cycle N+ITERS+1 (N+33). Special-case divides: done_o at N+1.
- Operands are latched at acceptance; later changes on op_a_i/op_b_i/funct3_i are ignored.
- stall_o (combinational) = start_i & ~kill_i & (state != DONE). It is low during DONE so the same instruction is not restarted; a back-to-back M-op is seen in IDLE the following cycle.
- Signed ops:
  - Operate on magnitudes and negate at the end.
  - MUL*/sign: negate the full 2·XLEN product if operand signs differ. MULHSU treats op_b as unsigned.
  - Quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
- Results:
  - MUL: low XLEN bits of the product; MULH/MULHSU/MULHU: high XLEN bits.
  - Divide by zero: quotient = all-ones (DIVU/DIV), remainder = op_a.
  - Overflow: DIV = 0x8000_0000, REM = 0.
- kill_i:
  - In MUL/DIV/DONE: next state IDLE, done_o low next cycle, result_o holds its old value.
  - In IDLE: suppresses acceptance.
  - kill_i has priority over start_i.
- result_o holds its last value outside DONE; consumers qualify it with done_o.
- Reset mid-operation: immediate IDLE with no done_o pulse.

Optional Feature:
- MULDIV_FAST_MUL_EN:
  - Defined: multiplies use a single-cycle combinational XLEN×XLEN product; IDLE → DONE directly, done_o at N+1. Divides are unchanged.
  - Undefined: iterative multiply only; no multiplier array is inferred.

Decomposition:
- cpu_types package:
  - muldiv_op_e enum: funct3 encodings MUL=000 … REMU=111.
  - muldiv_state_e {IDLE, MUL, DIV, DONE}.
  - Constant MULDIV_ITERS = 32.
- One sub-module is natural: muldiv_iter_dp. It holds the accumulator/remainder and shift registers and implements one shift-add or restore step per enable. ex_muldiv_seq keeps the FSM, counter, sign fixup and stall logic.

Test Plan:
- MUL 7 × -3 (start held) → stall_o high cycles N..N+32, done_o at N+33, result 0xFFFF_FFEB; stall_o low in the done cycle.
- MULHU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFE; MULH same operands → 0x0000_0000; MULHSU -1 × 0xFFFF_FFFF → 0xFFFF_FFFF.
- DIV -7 / 2 → 0xFFFF_FFFD; REM -7 / 2 → 0xFFFF_FFFF; DIVU 100 / 7 → 14; REMU → 2; each done at N+33.
- Div by zero: DIVU 5/0 → 0xFFFF_FFFF, REM 5/0 → 5. Overflow: DIV 0x8000_0000 / -1 → 0x8000_0000, REM → 0. All done at N+1.
- kill_i at cycle N+10 of a DIV → IDLE at N+11, no done_o; new start at N+12 completes at N+45. Back-to-back MULs → second accepted the cycle after the first done.
- rst_n low at N+5 → outputs 0 immediately. With MULDIV_FAST_MUL_EN: MUL 3 × 4 → done at N+1, result 12.
